// File: rtl/pool2_controller_if.sv
// Bus bundle between pool2_controller and the pool units / IFM RAMs it sequences.
// Widths are derived from the same layer parameters the controller uses.
interface pool2_controller_if #(
  parameter int IFM_SIZE        = 14,
  parameter int IFM_DEPTH       = 3,
  parameter int KERNAL_SIZE     = 2,
  parameter int NUMBER_OF_UNITS = 3
);
  localparam int IFM_SIZE_NEXT         = (IFM_SIZE - KERNAL_SIZE) / 2 + 1;
  localparam int PASSES                = (IFM_DEPTH + NUMBER_OF_UNITS - 1) / NUMBER_OF_UNITS;
  localparam int ADDRESS_SIZE_IFM      = $clog2(IFM_SIZE * IFM_SIZE);
  localparam int ADDRESS_SIZE_NEXT_IFM = $clog2(IFM_SIZE_NEXT * IFM_SIZE_NEXT);
  localparam int PASS_W                = $clog2(PASSES + 1);

  logic                             start;
  logic [ADDRESS_SIZE_IFM-1:0]      ifm_address_read_A;
  logic [ADDRESS_SIZE_IFM-1:0]      ifm_address_read_B;
  logic                             fifo_enable;
  logic                             pool_enable;
  logic [ADDRESS_SIZE_NEXT_IFM-1:0] ofm_address_write;
  logic                             ofm_write_enable;
  logic [PASS_W-1:0]                pass_index;
  logic                             busy;
  logic                             done;
  logic [15:0]                      busy_cycles;

  modport master (
    input  start,
    output ifm_address_read_A, ifm_address_read_B, fifo_enable, pool_enable,
           ofm_address_write, ofm_write_enable, pass_index, busy, done, busy_cycles
  );

  modport slave (
    output start,
    input  ifm_address_read_A, ifm_address_read_B, fifo_enable, pool_enable,
           ofm_address_write, ofm_write_enable, pass_index, busy, done, busy_cycles
  );
endinterface

// File: rtl/pool2_controller.sv
// LeNet-5 pool2 sequencer: 2x2-window read scan, pool strobes and next-IFM write addressing.
// Optional busy-cycle performance counter enabled by defining POOL2_CTRL_PERF_COUNTER_EN.
module pool2_controller #(
  parameter int IFM_SIZE        = 14,
  parameter int IFM_DEPTH       = 3,
  parameter int KERNAL_SIZE     = 2,
  parameter int NUMBER_OF_UNITS = 3
) (
  input logic clk,
  input logic reset,
  pool2_controller_if.master bus
);
  localparam int IFM_SIZE_NEXT = (IFM_SIZE - KERNAL_SIZE) / 2 + 1;
  localparam int PASSES        = (IFM_DEPTH + NUMBER_OF_UNITS - 1) / NUMBER_OF_UNITS;
  localparam int AW            = $clog2(IFM_SIZE * IFM_SIZE);
  localparam int WAW           = $clog2(IFM_SIZE_NEXT * IFM_SIZE_NEXT);
  localparam int PASS_W        = $clog2(PASSES + 1);
  localparam int COLS          = 2 * IFM_SIZE_NEXT;
  localparam int COL_W         = $clog2(COLS);
  localparam int ROW_W         = (IFM_SIZE_NEXT > 1) ? $clog2(IFM_SIZE_NEXT) : 1;
  localparam int WRITES        = IFM_SIZE_NEXT * IFM_SIZE_NEXT;
  // Jump from the last column of one row pair to column 0 two rows down.
  localparam int ROW_STEP      = 2 * IFM_SIZE - (COLS - 1);

  typedef enum logic [1:0] {IDLE, RUN, DRAIN, DONE} state_t;

  state_t            state_q;
  logic [COL_W-1:0]  col_q, col_d;
  logic [ROW_W-1:0]  row_q, row_d;
  logic [PASS_W-1:0] rd_pass_q, rd_pass_d;
  logic [AW-1:0]     addr_a_q, addr_a_d, addr_b_q, addr_b_d;
  logic              rd_vld_q, fifo_en_q, fifo_odd_q, pool_en_q, wr_en_q;
  logic [WAW-1:0]    wr_addr_q;
  logic [PASS_W-1:0] wr_pass_q;
  logic [1:0]        drain_q;
  logic              busy_q, done_q;
  logic              last_col, last_row, last_pass, last_read;

  assign last_col  = (col_q == COL_W'(COLS - 1));
  assign last_row  = (row_q == ROW_W'(IFM_SIZE_NEXT - 1));
  assign last_pass = (rd_pass_q == PASS_W'(PASSES - 1));
  assign last_read = last_col && last_row && last_pass;

  always_comb begin
    col_d     = col_q + COL_W'(1);
    row_d     = row_q;
    rd_pass_d = rd_pass_q;
    addr_a_d  = addr_a_q + AW'(1);
    if (last_col) begin
      col_d = '0;
      if (last_row) begin
        row_d     = '0;
        rd_pass_d = rd_pass_q + PASS_W'(1);
        addr_a_d  = '0;
      end else begin
        row_d    = row_q + ROW_W'(1);
        addr_a_d = addr_a_q + AW'(ROW_STEP);
      end
    end
    addr_b_d = addr_a_d + AW'(IFM_SIZE);
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q    <= IDLE;
      col_q      <= '0;
      row_q      <= '0;
      rd_pass_q  <= '0;
      addr_a_q   <= '0;
      addr_b_q   <= '0;
      rd_vld_q   <= 1'b0;
      fifo_en_q  <= 1'b0;
      fifo_odd_q <= 1'b0;
      pool_en_q  <= 1'b0;
      wr_en_q    <= 1'b0;
      wr_addr_q  <= '0;
      wr_pass_q  <= '0;
      drain_q    <= '0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
    end else begin
      // col_q[0] still describes the read on the bus, so it tags odd columns.
      fifo_en_q  <= rd_vld_q;
      fifo_odd_q <= rd_vld_q & col_q[0];
      pool_en_q  <= fifo_odd_q;
      wr_en_q    <= pool_en_q;

      if (wr_en_q) begin
        if (wr_addr_q == WAW'(WRITES - 1)) begin
          wr_addr_q <= '0;
          wr_pass_q <= wr_pass_q + PASS_W'(1);
        end else begin
          wr_addr_q <= wr_addr_q + WAW'(1);
        end
      end

      case (state_q)
        IDLE: begin
          if (bus.start) begin
            state_q   <= RUN;
            busy_q    <= 1'b1;
            col_q     <= '0;
            row_q     <= '0;
            rd_pass_q <= '0;
            addr_a_q  <= '0;
            addr_b_q  <= AW'(IFM_SIZE);
            rd_vld_q  <= 1'b1;
            wr_addr_q <= '0;
            wr_pass_q <= '0;
          end
        end
        RUN: begin
          if (last_read) begin
            state_q  <= DRAIN;
            rd_vld_q <= 1'b0;
            drain_q  <= '0;
          end else begin
            col_q     <= col_d;
            row_q     <= row_d;
            rd_pass_q <= rd_pass_d;
            addr_a_q  <= addr_a_d;
            addr_b_q  <= addr_b_d;
          end
        end
        DRAIN: begin
          drain_q <= drain_q + 2'd1;
          if (drain_q == 2'd2) begin
            state_q <= DONE;
            done_q  <= 1'b1;
          end
        end
        DONE: begin
          state_q <= IDLE;
          done_q  <= 1'b0;
          busy_q  <= 1'b0;
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign bus.ifm_address_read_A = addr_a_q;
  assign bus.ifm_address_read_B = addr_b_q;
  assign bus.fifo_enable        = fifo_en_q;
  assign bus.pool_enable        = pool_en_q;
  assign bus.ofm_address_write  = wr_addr_q;
  assign bus.ofm_write_enable   = wr_en_q;
  assign bus.pass_index         = wr_pass_q;
  assign bus.busy               = busy_q;
  assign bus.done               = done_q;

`ifdef POOL2_CTRL_PERF_COUNTER_EN
  logic [15:0] busy_cnt_q;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      busy_cnt_q <= '0;
    end else if (state_q == IDLE && bus.start) begin
      busy_cnt_q <= '0;
    end else if (busy_q && busy_cnt_q != 16'hFFFF) begin
      busy_cnt_q <= busy_cnt_q + 16'd1;
    end
  end

  assign bus.busy_cycles = busy_cnt_q;
`else
  assign bus.busy_cycles = 16'd0;
`endif
endmodule

// File: tb/tb_pool2_controller.sv
// Bench for pool2_controller: default layer plus a 5x5, two-pass layer, scoreboard on reads/writes,
// spot-check vector table, mid-run reset and held-start sequences.
module tb_pool2_controller;
  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  pool2_controller_if bus0 ();
  pool2_controller_if #(.IFM_SIZE(5), .IFM_DEPTH(6), .NUMBER_OF_UNITS(3)) bus1 ();

  pool2_controller dut0 (.clk(clk), .reset(reset), .bus(bus0));
  pool2_controller #(.IFM_SIZE(5), .IFM_DEPTH(6), .NUMBER_OF_UNITS(3)) dut1 (
    .clk(clk), .reset(reset), .bus(bus1));

  int checks = 0;
  int failures = 0;

  typedef struct { int a; int b; } rd_t;
  typedef struct { int addr; int pass; } wr_t;
  rd_t rdq[2][$];
  wr_t wrq[2][$];
  int  prev_a[2];
  int  prev_b[2];
  int  pe_cnt[2];

  typedef struct {
    int off; int a; int b; bit fe; bit pe; bit we; int wa; bit busy; bit done;
  } vec_t;
  vec_t vec[14];

  task automatic chk(input string name, input int act, input int req);
    checks++;
    if (act != req) begin
      failures++;
      $display("FAIL %s actual=%0d required=%0d", name, act, req);
    end
  endtask

  // Expected stream built straight from the scan-order formulas.
  task automatic push_layer(input int d, input int ifm, input int n, input int passes);
    for (int q = 0; q < passes; q++)
      for (int p = 0; p < n; p++)
        for (int c = 0; c < 2 * n; c++) begin
          rd_t r;
          r.a = 2 * p * ifm + c;
          r.b = r.a + ifm;
          rdq[d].push_back(r);
          if (c % 2 == 1) begin
            wr_t w;
            w.addr = p * n + c / 2;
            w.pass = q;
            wrq[d].push_back(w);
          end
        end
  endtask

  task automatic mon(input int d, input bit fe, input bit pe, input bit we,
                     input int a, input int b, input int wa, input int pi);
    if (fe) begin
      if (rdq[d].size() == 0) chk($sformatf("rd_extra%0d", d), 1, 0);
      else begin
        rd_t r = rdq[d].pop_front();
        chk($sformatf("rdA%0d", d), prev_a[d], r.a);
        chk($sformatf("rdB%0d", d), prev_b[d], r.b);
      end
    end
    if (we) begin
      if (wrq[d].size() == 0) chk($sformatf("wr_extra%0d", d), 1, 0);
      else begin
        wr_t w = wrq[d].pop_front();
        chk($sformatf("wr_addr%0d", d), wa, w.addr);
        chk($sformatf("wr_pass%0d", d), pi, w.pass);
      end
    end
    if (pe) pe_cnt[d]++;
    prev_a[d] = a;
    prev_b[d] = b;
  endtask

  always @(negedge clk)
    mon(0, bus0.fifo_enable, bus0.pool_enable, bus0.ofm_write_enable,
        int'(bus0.ifm_address_read_A), int'(bus0.ifm_address_read_B),
        int'(bus0.ofm_address_write), int'(bus0.pass_index));

  always @(negedge clk)
    mon(1, bus1.fifo_enable, bus1.pool_enable, bus1.ofm_write_enable,
        int'(bus1.ifm_address_read_A), int'(bus1.ifm_address_read_B),
        int'(bus1.ofm_address_write), int'(bus1.pass_index));

  task automatic wait_done0(input int limit, output int off);
    off = 0;
    while (!bus0.done && off < limit) begin
      @(negedge clk);
      off++;
    end
  endtask

  initial begin
    int off;
    int pe_base;
    int dones;
    // off = negedges after the start-sampling edge (0 = first read on the bus)
    vec[0]  = '{0,   0,   14,  0, 0, 0, 0,  1, 0};
    vec[1]  = '{1,   1,   15,  1, 0, 0, 0,  1, 0};
    vec[2]  = '{2,   2,   16,  1, 0, 0, 0,  1, 0};
    vec[3]  = '{3,   3,   17,  1, 1, 0, 0,  1, 0};
    vec[4]  = '{4,   4,   18,  1, 0, 1, 0,  1, 0};
    vec[5]  = '{5,   5,   19,  1, 1, 0, 1,  1, 0};
    vec[6]  = '{27,  41,  55,  1, 1, 0, 12, 1, 0};
    vec[7]  = '{30,  58,  72,  1, 0, 1, 13, 1, 0};
    vec[8]  = '{97,  181, 195, 1, 1, 0, 47, 1, 0};
    vec[9]  = '{98,  181, 195, 1, 0, 1, 47, 1, 0};
    vec[10] = '{99,  181, 195, 0, 1, 0, 48, 1, 0};
    vec[11] = '{100, 181, 195, 0, 0, 1, 48, 1, 0};
    vec[12] = '{101, 181, 195, 0, 0, 0, 0,  1, 1};
    vec[13] = '{102, 181, 195, 0, 0, 0, 0,  0, 0};

    reset = 1'b1;
    bus0.start = 1'b0;
    bus1.start = 1'b0;
    repeat (3) @(negedge clk);
    chk("rst_A", int'(bus0.ifm_address_read_A), 0);
    chk("rst_B", int'(bus0.ifm_address_read_B), 0);
    chk("rst_fe", int'(bus0.fifo_enable), 0);
    chk("rst_pe", int'(bus0.pool_enable), 0);
    chk("rst_we", int'(bus0.ofm_write_enable), 0);
    chk("rst_wa", int'(bus0.ofm_address_write), 0);
    chk("rst_pass", int'(bus0.pass_index), 0);
    chk("rst_busy", int'(bus0.busy), 0);
    chk("rst_done", int'(bus0.done), 0);
    chk("rst_bc", int'(bus0.busy_cycles), 0);
    reset = 1'b0;
    @(negedge clk);

    // Layer 1: default geometry, spot vectors plus scoreboard.
    push_layer(0, 14, 7, 1);
    pe_base = pe_cnt[0];
    bus0.start = 1'b1;
    @(negedge clk);
    bus0.start = 1'b0;
    off = 0;
    for (int i = 0; i < 14; i++) begin
      while (off < vec[i].off) begin
        @(negedge clk);
        off++;
      end
      chk($sformatf("v%0d_A", off), int'(bus0.ifm_address_read_A), vec[i].a);
      chk($sformatf("v%0d_B", off), int'(bus0.ifm_address_read_B), vec[i].b);
      chk($sformatf("v%0d_fe", off), int'(bus0.fifo_enable), int'(vec[i].fe));
      chk($sformatf("v%0d_pe", off), int'(bus0.pool_enable), int'(vec[i].pe));
      chk($sformatf("v%0d_we", off), int'(bus0.ofm_write_enable), int'(vec[i].we));
      chk($sformatf("v%0d_wa", off), int'(bus0.ofm_address_write), vec[i].wa);
      chk($sformatf("v%0d_busy", off), int'(bus0.busy), int'(vec[i].busy));
      chk($sformatf("v%0d_done", off), int'(bus0.done), int'(vec[i].done));
    end
`ifdef POOL2_CTRL_PERF_COUNTER_EN
    chk("busy_cycles", int'(bus0.busy_cycles), 102);
`else
    chk("busy_cycles", int'(bus0.busy_cycles), 0);
`endif
    chk("l1_pool_count", pe_cnt[0] - pe_base, 49);
    chk("l1_rd_left", rdq[0].size(), 0);
    chk("l1_wr_left", wrq[0].size(), 0);
    $display("layer dut0 default: done_off=%0d pools=%0d", off, pe_cnt[0] - pe_base);

    // Layer 2: 5x5 maps, two passes, odd edge row/column skipped.
    push_layer(1, 5, 2, 2);
    pe_base = pe_cnt[1];
    bus1.start = 1'b1;
    @(negedge clk);
    bus1.start = 1'b0;
    off = 0;
    while (!bus1.done && off < 60) begin
      @(negedge clk);
      off++;
    end
    chk("l2_done_off", off, 19);
    chk("l2_pass_after", int'(bus1.pass_index), 2);
    @(negedge clk);
    chk("l2_busy_end", int'(bus1.busy), 0);
    chk("l2_pool_count", pe_cnt[1] - pe_base, 8);
    chk("l2_rd_left", rdq[1].size(), 0);
    chk("l2_wr_left", wrq[1].size(), 0);
    $display("layer dut1 5x5x6: done_off=%0d pools=%0d", off, pe_cnt[1] - pe_base);

    // Layer 3: asynchronous reset in the middle of RUN.
    push_layer(0, 14, 7, 1);
    bus0.start = 1'b1;
    @(negedge clk);
    bus0.start = 1'b0;
    repeat (50) @(negedge clk);
    #2 reset = 1'b1;
    #1;
    chk("mid_rst_A", int'(bus0.ifm_address_read_A), 0);
    chk("mid_rst_B", int'(bus0.ifm_address_read_B), 0);
    chk("mid_rst_fe", int'(bus0.fifo_enable), 0);
    chk("mid_rst_we", int'(bus0.ofm_write_enable), 0);
    chk("mid_rst_wa", int'(bus0.ofm_address_write), 0);
    chk("mid_rst_busy", int'(bus0.busy), 0);
    rdq[0].delete();
    wrq[0].delete();
    @(negedge clk);
    @(negedge clk);
    reset = 1'b0;
    dones = 0;
    for (int i = 0; i < 120; i++) begin
      @(negedge clk);
      if (bus0.done) dones++;
    end
    chk("mid_rst_no_done", dones, 0);
    chk("mid_rst_idle", int'(bus0.busy), 0);
    $display("layer dut0 reset mid-run: dones=%0d", dones);

    // Layer 4: restart after reset.
    push_layer(0, 14, 7, 1);
    bus0.start = 1'b1;
    @(negedge clk);
    bus0.start = 1'b0;
    chk("restart_A", int'(bus0.ifm_address_read_A), 0);
    chk("restart_B", int'(bus0.ifm_address_read_B), 14);
    wait_done0(150, off);
    chk("restart_done_off", off, 101);
    repeat (2) @(negedge clk);
    $display("layer dut0 restart: done_off=%0d", off);

    // Layers 5+6: start held high; exactly one layer, then a new one from IDLE.
    push_layer(0, 14, 7, 1);
    push_layer(0, 14, 7, 1);
    pe_base = pe_cnt[0];
    bus0.start = 1'b1;
    @(negedge clk);
    wait_done0(150, off);
    chk("held_done_off", off, 101);
    chk("held_pool_count", pe_cnt[0] - pe_base, 49);
    @(negedge clk);
    chk("held_idle_busy", int'(bus0.busy), 0);
`ifdef POOL2_CTRL_PERF_COUNTER_EN
    chk("held_busy_cycles", int'(bus0.busy_cycles), 102);
`else
    chk("held_busy_cycles", int'(bus0.busy_cycles), 0);
`endif
    @(negedge clk);
    chk("held_rerun_busy", int'(bus0.busy), 1);
    chk("held_rerun_A", int'(bus0.ifm_address_read_A), 0);
    bus0.start = 1'b0;
    wait_done0(150, off);
    chk("held_rerun_done_off", off, 101);
    repeat (3) @(negedge clk);
    chk("held_end_busy", int'(bus0.busy), 0);
    chk("held_pool_total", pe_cnt[0] - pe_base, 98);
    chk("held_rd_left", rdq[0].size(), 0);
    chk("held_wr_left", wrq[0].size(), 0);
    $display("layer dut0 held start: two layers, pools=%0d", pe_cnt[0] - pe_base);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

// File: doc/pool2_controller.md
# pool2_controller

Sequencer for the second average-pooling stage of LeNet-5. It scans the conv2 output feature maps in 2x2-window order and drives two IFM RAM read addresses per cycle, which feed the A/B data inputs of the pool units. It times the pool units' `fifo_enable` and `pool_enable` strobes and produces the write address and write strobe for the next-layer IFM RAM. All `NUMBER_OF_UNITS` pool units share its outputs; each unit handles one feature map of the current pass.

## Interface
- `IFM_SIZE`, 14, input feature-map side length
- `IFM_DEPTH`, 3, number of input feature maps
- `KERNAL_SIZE`, 2, pooling window side; stride is fixed at 2
- `NUMBER_OF_UNITS`, 3, pool units working in parallel
- `IFM_SIZE_NEXT`, (IFM_SIZE-KERNAL_SIZE)/2+1, output side length
- `PASSES`, ceil(IFM_DEPTH/NUMBER_OF_UNITS), number of depth passes
- `ADDRESS_SIZE_IFM`, $clog2(IFM_SIZE*IFM_SIZE), read address width
- `ADDRESS_SIZE_NEXT_IFM`, $clog2(IFM_SIZE_NEXT*IFM_SIZE_NEXT), write address width

Ports:
- `clk` in 1: single clock, rising edge
- `reset` in 1: asynchronous, active-high
- `start` in 1: begin a full layer; sampled only in IDLE
- `ifm_address_read_A` out ADDRESS_SIZE_IFM: top-row pixel address
- `ifm_address_read_B` out ADDRESS_SIZE_IFM: bottom-row pixel address
- `fifo_enable` out 1: read data is valid at the pool-unit inputs
- `pool_enable` out 1: the pool-unit FIFO holds a complete 2x2 window
- `ofm_address_write` out ADDRESS_SIZE_NEXT_IFM: next-IFM write address
- `ofm_write_enable` out 1: pool-unit output registers are valid
- `pass_index` out $clog2(PASSES+1): depth pass of the current write
- `busy` out 1: high in every state except IDLE
- `done` out 1: single-cycle pulse at end of layer
- `busy_cycles` out 16: performance counter (see Configuration)

## Operation
- FSM states: IDLE, RUN, DRAIN, DONE.
  - IDLE → RUN when `start`=1.
  - RUN → DRAIN after the last read of the last pass.
  - DRAIN lasts exactly 3 cycles, then → DONE.
  - DONE lasts 1 cycle (`done`=1), then → IDLE.
- RUN scan order:
  - pass `q` outermost, then row pair `p` in 0..IFM_SIZE_NEXT-1, then column `c` in 0..2*IFM_SIZE_NEXT-1.
  - `ifm_address_read_A` = 2p*IFM_SIZE + c; `ifm_address_read_B` = A + IFM_SIZE.
  - For odd IFM_SIZE, the last row and column are never read.
  - One read pair is issued per RUN cycle, with no bubbles, including at pass boundaries.
- Reads per pass: R = 2*IFM_SIZE_NEXT². Writes per pass: W = IFM_SIZE_NEXT².
- Pipeline is a valid/odd-column shift register; a read issued in cycle t produces:
  - `fifo_enable` in t+1 (RAM read latency is 1 cycle),
  - `pool_enable` in t+2, only for odd `c`,
  - `ofm_write_enable` in t+3, only for odd `c`.
- `ofm_address_write`:
  - 0 at the first write of each pass, then +1 per write, running 0..W-1.
  - Increments after each asserted `ofm_write_enable`.
  - Wraps to 0 when `pass_index` advances.
- `pass_index` follows the write stream, not the read stream: it increments in the cycle after the W-th write of a pass.
- `start` in RUN, DRAIN or DONE is ignored; no queueing.
- Counters are sized so that no address ever exceeds IFM_SIZE²-1 (read) or W-1 (write).

## Timing
- Reset values:
  - all outputs 0, including both read addresses, `ofm_address_write`, `pass_index` and `busy_cycles`;
  - FSM in IDLE; pipeline valid bits cleared.
- `reset` asserted mid-operation clears everything immediately and asynchronously. No partial write or `done` pulse follows.
- With `start` sampled at edge k:
  - first read address is valid in cycle k+1;
  - last read in cycle k+R*PASSES;
  - last `ofm_write_enable` in cycle k+R*PASSES+3;
  - `done` in cycle k+R*PASSES+4;
  - IDLE again in cycle k+R*PASSES+5.
- At defaults (R=98, PASSES=1): `done` appears 102 cycles after the start edge.
- Outside RUN, the read addresses hold their last values; `fifo_enable` is 0 except while the pipeline drains.

## Configuration
- `POOL2_CTRL_PERF_COUNTER_EN`
  - Defined: `busy_cycles` increments once per cycle while `busy`=1, saturates at 16'hFFFF, and clears on `reset` and on every accepted `start`.
  - Not defined: `busy_cycles` is tied to 0 and no counter flops are synthesised.

## Test plan
- Reset, then `start` pulse (defaults) → first addresses A=0, B=14; `pool_enable` pulses 49 times; `ofm_address_write` runs 0..48; `done` one cycle at start edge +102.
- Check the address sequence at row pair p=1, c=13 → A=41, B=55; the corresponding write address is 13, asserted 3 cycles later.
- IFM_SIZE=5 → only columns and rows 0..3 are read; 4 writes per pass; addresses 4, 9, 14, 19, 20..24 never appear.
- IFM_DEPTH=6, NUMBER_OF_UNITS=3 → PASSES=2, 196 reads with no gap between passes; `pass_index` goes 0→1 after the 49th write; the write address wraps to 0; `done` at start edge +200.
- `reset` asserted at cycle 50 of RUN → all outputs 0 in the same cycle; no `done`; a subsequent `start` restarts from address 0.
- `start` held high throughout the run → exactly one layer is processed; a second run begins only if `start` is still high in IDLE. With the macro defined, `busy_cycles` = 102 after a single run.
